// File: rtl/i2c_fifo.sv
// First-word-fall-through FIFO shared by the APB bridge and the I2C core.
// Head word is presented combinationally from the read pointer; status is derived from a registered count.
module i2c_fifo #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              WR_EN,
    input  logic [DWIDTH-1:0] DATA_IN,
    input  logic              RD_EN,
    output logic [DWIDTH-1:0] DATA_OUT,
    output logic              FULL,
    output logic              EMPTY,
    output logic [AWIDTH:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH+1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;
    logic mem_we;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    always_comb begin
        pop_ok      = RD_EN && !empty;
        // A pop on a full FIFO frees the slot the simultaneous push fills.
        push_ok     = WR_EN && (!full || pop_ok);
        mem_we      = push_ok && !PRESET;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (PRESET) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
            overflow_d  = WR_EN && !push_ok;
            underflow_d = RD_EN && empty;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally left uninitialised by reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge PCLK) begin
                if (mem_we && (wr_ptr_q == AWIDTH'(gi))) begin
                    mem[gi] <= DATA_IN;
                end
            end
        end
    endgenerate

    assign DATA_OUT  = empty ? '0 : mem[rd_ptr_q];
    assign FULL      = full;
    assign EMPTY     = empty;
    assign COUNT     = count_q;
    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_i2c_fifo.sv
// Scoreboard bench for i2c_fifo: each driven cycle queues its expected post-edge state,
// and a negedge monitor pops and compares against the DUT outputs.
module tb_i2c_fifo;

    localparam int DW = 32;
    localparam int AW = 2;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          WR_EN;
    logic [DW-1:0] DATA_IN;
    logic          RD_EN;
    logic [DW-1:0] DATA_OUT;
    logic          FULL;
    logic          EMPTY;
    logic [AW:0]   COUNT;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    i2c_fifo #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .WR_EN     (WR_EN),
        .DATA_IN   (DATA_IN),
        .RD_EN     (RD_EN),
        .DATA_OUT  (DATA_OUT),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT),
        .OVERFLOW  (OVERFLOW),
        .UNDERFLOW (UNDERFLOW)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string         tag;
        int            cnt;
        logic [DW-1:0] dout;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t exp_q [$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    function automatic void chk(input string tag, input string field,
                                input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks_total++;
        if (act === req) begin
            checks_passed++;
        end else begin
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", tag, field, act, req);
        end
    endfunction

    // Monitor: one transaction line per checked cycle.
    always @(negedge PCLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "COUNT",     DW'(COUNT),     DW'(e.cnt));
            chk(e.tag, "EMPTY",     DW'(EMPTY),     DW'(e.cnt == 0));
            chk(e.tag, "FULL",      DW'(FULL),      DW'(e.cnt == (1 << AW)));
            chk(e.tag, "DATA_OUT",  DATA_OUT,       e.dout);
            chk(e.tag, "OVERFLOW",  DW'(OVERFLOW),  DW'(e.ovf));
            chk(e.tag, "UNDERFLOW", DW'(UNDERFLOW), DW'(e.unf));
            $display("txn %-10s count=%0d empty=%0b full=%0b dout=0x%0h ovf=%0b unf=%0b",
                     e.tag, COUNT, EMPTY, FULL, DATA_OUT, OVERFLOW, UNDERFLOW);
        end
    end

    task automatic step(input logic rst, input logic wr, input logic rd,
                        input logic [DW-1:0] din, input int cnt,
                        input logic [DW-1:0] dout, input logic ovf, input logic unf,
                        input string tag);
        exp_t e;
        PRESET  = rst;
        WR_EN   = wr;
        RD_EN   = rd;
        DATA_IN = din;
        @(posedge PCLK);
        e.tag  = tag;
        e.cnt  = cnt;
        e.dout = dout;
        e.ovf  = ovf;
        e.unf  = unf;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        PRESET  = 1'b1;
        WR_EN   = 1'b0;
        RD_EN   = 1'b0;
        DATA_IN = '0;

        //     rst   wr    rd    din    cnt dout   ovf   unf
        step(1'b1, 1'b0, 1'b0, 32'h00, 0, 32'h00, 1'b0, 1'b0, "reset");
        step(1'b0, 1'b0, 1'b0, 32'h00, 0, 32'h00, 1'b0, 1'b0, "idle");
        step(1'b0, 1'b1, 1'b0, 32'hA1, 1, 32'hA1, 1'b0, 1'b0, "push_a1");
        step(1'b0, 1'b1, 1'b0, 32'hB2, 2, 32'hA1, 1'b0, 1'b0, "push_b2");
        step(1'b0, 1'b1, 1'b0, 32'hC3, 3, 32'hA1, 1'b0, 1'b0, "push_c3");
        step(1'b0, 1'b1, 1'b0, 32'hD4, 4, 32'hA1, 1'b0, 1'b0, "push_d4");
        step(1'b0, 1'b1, 1'b0, 32'hEE, 4, 32'hA1, 1'b1, 1'b0, "ovf_ee");
        step(1'b0, 1'b0, 1'b0, 32'h00, 4, 32'hA1, 1'b0, 1'b0, "ovf_clr");
        step(1'b0, 1'b0, 1'b1, 32'h00, 3, 32'hB2, 1'b0, 1'b0, "pop1");
        step(1'b0, 1'b0, 1'b1, 32'h00, 2, 32'hC3, 1'b0, 1'b0, "pop2");
        step(1'b0, 1'b0, 1'b1, 32'h00, 1, 32'hD4, 1'b0, 1'b0, "pop3");
        step(1'b0, 1'b0, 1'b1, 32'h00, 0, 32'h00, 1'b0, 1'b0, "pop4");
        step(1'b0, 1'b0, 1'b1, 32'h00, 0, 32'h00, 1'b0, 1'b1, "unf");
        step(1'b0, 1'b1, 1'b1, 32'h55, 1, 32'h55, 1'b0, 1'b1, "wr_rd_emp");
        step(1'b0, 1'b0, 1'b0, 32'h00, 1, 32'h55, 1'b0, 1'b0, "unf_clr");
        step(1'b0, 1'b1, 1'b0, 32'h66, 2, 32'h55, 1'b0, 1'b0, "push_66");
        step(1'b0, 1'b1, 1'b0, 32'h67, 3, 32'h55, 1'b0, 1'b0, "push_67");
        step(1'b0, 1'b1, 1'b0, 32'h68, 4, 32'h55, 1'b0, 1'b0, "push_68");
        // Full with simultaneous push/pop: contents rotate through the wrap point.
        step(1'b0, 1'b1, 1'b1, 32'h70, 4, 32'h66, 1'b0, 1'b0, "full_rw0");
        step(1'b0, 1'b1, 1'b1, 32'h71, 4, 32'h67, 1'b0, 1'b0, "full_rw1");
        step(1'b0, 1'b1, 1'b1, 32'h72, 4, 32'h68, 1'b0, 1'b0, "full_rw2");
        step(1'b0, 1'b1, 1'b1, 32'h73, 4, 32'h70, 1'b0, 1'b0, "full_rw3");
        step(1'b0, 1'b1, 1'b1, 32'h74, 4, 32'h71, 1'b0, 1'b0, "full_rw4");
        step(1'b0, 1'b1, 1'b1, 32'h75, 4, 32'h72, 1'b0, 1'b0, "full_rw5");
        step(1'b0, 1'b0, 1'b1, 32'h00, 3, 32'h73, 1'b0, 1'b0, "drain1");
        step(1'b0, 1'b0, 1'b1, 32'h00, 2, 32'h74, 1'b0, 1'b0, "drain2");
        step(1'b0, 1'b0, 1'b1, 32'h00, 1, 32'h75, 1'b0, 1'b0, "drain3");
        step(1'b0, 1'b0, 1'b1, 32'h00, 0, 32'h00, 1'b0, 1'b0, "drain4");
        step(1'b0, 1'b1, 1'b0, 32'h81, 1, 32'h81, 1'b0, 1'b0, "push_81");
        step(1'b0, 1'b1, 1'b0, 32'h82, 2, 32'h81, 1'b0, 1'b0, "push_82");
        step(1'b0, 1'b1, 1'b0, 32'h83, 3, 32'h81, 1'b0, 1'b0, "push_83");
        step(1'b1, 1'b1, 1'b0, 32'h99, 0, 32'h00, 1'b0, 1'b0, "rst_wr");
        step(1'b0, 1'b1, 1'b0, 32'h11, 1, 32'h11, 1'b0, 1'b0, "push_11");
        step(1'b0, 1'b0, 1'b1, 32'h00, 0, 32'h00, 1'b0, 1'b0, "pop_11");
        step(1'b0, 1'b0, 1'b1, 32'h00, 0, 32'h00, 1'b0, 1'b1, "unf_b2b0");
        step(1'b0, 1'b0, 1'b1, 32'h00, 0, 32'h00, 1'b0, 1'b1, "unf_b2b1");
        step(1'b0, 1'b0, 1'b0, 32'h00, 0, 32'h00, 1'b0, 1'b0, "final");

        // Bounded wait for the monitor to drain the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge PCLK);
        end
        checks_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end else begin
            checks_passed++;
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2c_fifo.md
Name: i2c_fifo

Overview:
- Synchronous first-word-fall-through FIFO between the APB bridge and the I2C core.
- Instantiated twice:
  - TX path: APB WR_ENA/WRITE_DATA_ON_TX push, I2C core pops.
  - RX path: I2C core pushes, APB RD_ENA pops, DATA_OUT drives READ_DATA_ON_RX, EMPTY drives RX_EMPTY.
- FWFT is required so PRDATA is valid in the same APB access cycle as RD_ENA.

Parameters:
- DWIDTH, 32, data word width in bits.
- AWIDTH, 2, address width; depth = 2**AWIDTH (default 4 entries).

Ports:
- PCLK  input  1  single clock; all state updates on rising edge.
- PRESET  input  1  synchronous reset, active-high, sampled on PCLK rising edge.
- WR_EN  input  1  push request; DATA_IN written when accepted.
- DATA_IN  input  DWIDTH  push data.
- RD_EN  input  1  pop request; removes the head entry when accepted.
- DATA_OUT  output  DWIDTH  head entry (FWFT); 0 when EMPTY.
- FULL  output  1  COUNT == 2**AWIDTH.
- EMPTY  output  1  COUNT == 0.
- COUNT  output  AWIDTH+1  number of stored entries.
- OVERFLOW  output  1  one-cycle pulse: a push was rejected.
- UNDERFLOW  output  1  one-cycle pulse: a pop was rejected.

Behaviour:
- Storage:
  - Array of 2**AWIDTH words.
  - Write pointer wr_ptr and read pointer rd_ptr, each AWIDTH bits, wrap modulo depth.
  - Separate registered count, AWIDTH+1 bits, 0..2**AWIDTH.
- FULL, EMPTY and COUNT are derived combinationally from the registered count. No extra latency.
- DATA_OUT:
  - Equals mem[rd_ptr] while EMPTY=0; forced to 0 while EMPTY=1.
  - After a push into an empty FIFO, DATA_OUT is valid in the cycle after the push edge.
  - After a pop, the next entry appears in the cycle after the pop edge.
- Push acceptance:
  - A push is accepted when WR_EN=1 and (FULL=0, or RD_EN=1 with the pop accepted).
  - On accept: mem[wr_ptr] <= DATA_IN; wr_ptr increments, wrapping from 2**AWIDTH-1 to 0.
- Pop acceptance:
  - A pop is accepted when RD_EN=1 and EMPTY=0.
  - On accept: rd_ptr increments with the same wrap.
- Count update:
  - +1 on push-only accept.
  - -1 on pop-only accept.
  - Unchanged when both are accepted, or when neither is.
- Simultaneous events:
  - Full, WR_EN=1, RD_EN=1: both accepted, count stays at max, FULL stays 1, no OVERFLOW.
  - Empty, WR_EN=1, RD_EN=1: push accepted, pop rejected. UNDERFLOW pulses; count becomes 1. The written word is not bypassed to DATA_OUT in the same cycle.
- Error pulses:
  - OVERFLOW is registered: it is 1 for exactly the cycle after a rejected push (WR_EN=1, FULL=1, RD_EN=0).
  - UNDERFLOW is registered: it is 1 for exactly the cycle after a rejected pop (RD_EN=1, EMPTY=1).
  - A rejected request never modifies pointers, count or memory.
  - Back-to-back rejected requests give consecutive pulse cycles.
- Reset (PRESET=1 at a rising edge):
  - wr_ptr, rd_ptr and count go to 0; OVERFLOW and UNDERFLOW go to 0.
  - Memory contents are not cleared.
  - After the edge, outputs are: EMPTY=1, FULL=0, COUNT=0, DATA_OUT=0.
  - Reset has priority over WR_EN/RD_EN in the same cycle; any request in that cycle is discarded, including mid-stream.
- No read-during-write hazard: a push writes at wr_ptr and DATA_OUT reads rd_ptr. When both are accepted while full, the pop frees the slot that the push fills.
- No combinational path from WR_EN or RD_EN to any output.

Test Plan:
- Reset then idle -> EMPTY=1, FULL=0, COUNT=0, DATA_OUT=0, OVERFLOW=UNDERFLOW=0.
- Push 0xA1, 0xB2, 0xC3, 0xD4 on 4 consecutive cycles -> COUNT 1,2,3,4; FULL=1 after the 4th edge; DATA_OUT=0xA1 from the cycle after the first push.
- With the FIFO full, push 0xEE with RD_EN=0 -> OVERFLOW=1 for one cycle; COUNT=4; head still 0xA1. Then 4 pops -> DATA_OUT 0xB2, 0xC3, 0xD4, then 0 with EMPTY=1.
- With the FIFO empty, RD_EN=1 -> UNDERFLOW=1 for one cycle, COUNT=0. Then WR_EN=RD_EN=1 with 0x55 while empty -> COUNT=1, UNDERFLOW=1, DATA_OUT=0x55.
- With the FIFO full, WR_EN=RD_EN=1 with 0x77 -> COUNT stays 4, no OVERFLOW, head advances. Repeat 6 times -> pointer wrap verified; output order matches input order.
- Push 3 words, then assert PRESET together with WR_EN=1 -> after the edge COUNT=0, EMPTY=1, DATA_OUT=0. A following push of 0x11 -> DATA_OUT=0x11 and COUNT=1.
